ram_loader: RTL and testbench

Boot-time program loader that fills the 16-word instruction/data RAM from a byte stream before the CPU runs. It is the write-side initiator for the RAM: it accepts program bytes over a valid/ready stream and drives the RAM write port. It then reads every loaded word back through the RAM's combinational read path and checks a stream checksum. It holds the CPU halted (`o_cpu_hold`) from start until the load finishes.

---
 rtl/ram_loader_if.sv | 36 +++
 rtl/ram_loader.sv | 138 +++++++++++++
 tb/tb_ram_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_if.sv
// Byte-stream input and RAM port of the boot-time program loader.
// The loader holds the master view; the stream source and RAM the slave view.
interface ram_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_ready;
    logic                  o_we;
    logic [DATA_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_bus_data;
    logic                  o_jmp_imme;
    logic [DATA_WIDTH-1:0] i_ram_data;

    modport master (
        input  i_valid,
        input  i_data,
        input  i_ram_data,
        output o_ready,
        output o_we,
        output o_addr,
        output o_bus_data,
        output o_jmp_imme
    );

    modport slave (
        output i_valid,
        output i_data,
        output i_ram_data,
        input  o_ready,
        input  o_we,
        input  o_addr,
        input  o_bus_data,
        input  o_jmp_imme
    );
endinterface

// File: rtl/ram_loader.sv
// Boot loader: streams N bytes into RAM, checks the stream checksum,
// reads every word back and re-checks it, holding the CPU meanwhile.
module ram_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_SIZE   = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [ADDR_WIDTH:0] i_len,
    ram_loader_if.master        bus,
    output logic                o_cpu_hold,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        VERIFY,
        DONE
    } state_e;

    localparam logic [ADDR_WIDTH:0] FULL_N = (ADDR_WIDTH+1)'(MEM_SIZE);

    state_e                state_q;
    logic [ADDR_WIDTH:0]   n_q;
    logic [ADDR_WIDTH:0]   n_d;
    logic [ADDR_WIDTH:0]   wr_idx_q;
    logic [ADDR_WIDTH:0]   wr_idx_d;
    logic [ADDR_WIDTH:0]   rd_idx_q;
    logic [ADDR_WIDTH:0]   rd_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] ck_q;
    logic [DATA_WIDTH-1:0] rx_sum_q;
    logic [DATA_WIDTH-1:0] rx_sum_d;
    logic [DATA_WIDTH-1:0] rd_sum_q;
    logic [DATA_WIDTH-1:0] rd_sum_d;
    logic [DATA_WIDTH-1:0] rd_chk;
    logic                  we_q;
    logic                  err_q;
    logic                  hs;

    // In CHECK, rx_sum_d already equals rx_sum + CK.
    always_comb begin
        n_d      = (i_len == '0 || i_len > FULL_N) ? FULL_N : i_len;
        hs       = bus.i_valid && bus.o_ready;
        wr_idx_d = wr_idx_q + 1'b1;
        rd_idx_d = rd_idx_q + 1'b1;
        rx_sum_d = rx_sum_q + bus.i_data;
        rd_sum_d = rd_sum_q + bus.i_ram_data;
        rd_chk   = rd_sum_d + ck_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            n_q      <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ck_q     <= '0;
            rx_sum_q <= '0;
            rd_sum_q <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_start) begin
                        n_q      <= n_d;
                        wr_idx_q <= '0;
                        rd_idx_q <= '0;
                        rx_sum_q <= '0;
                        rd_sum_q <= '0;
                        err_q    <= 1'b0;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        we_q     <= 1'b1;
                        addr_q   <= wr_idx_q[ADDR_WIDTH-1:0];
                        data_q   <= bus.i_data;
                        wr_idx_q <= wr_idx_d;
                        rx_sum_q <= rx_sum_d;
                        if (wr_idx_d == n_q) begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (hs) begin
                        ck_q     <= bus.i_data;
                        rd_idx_q <= '0;
                        state_q  <= VERIFY;
                        if (rx_sum_d != '0) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                VERIFY: begin
                    rd_sum_q <= rd_sum_d;
                    rd_idx_q <= rd_idx_d;
                    if (rd_idx_d == n_q) begin
                        state_q <= DONE;
                        if (rd_chk != '0) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready    = (state_q == LOAD) || (state_q == CHECK);
    assign bus.o_we       = we_q;
    assign bus.o_bus_data = data_q;
    assign bus.o_jmp_imme = 1'b0;
    assign bus.o_addr     = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}},
                             (state_q == VERIFY) ?
                             rd_idx_q[ADDR_WIDTH-1:0] : addr_q};
    assign o_busy         = (state_q != IDLE);
    assign o_cpu_hold     = (state_q != IDLE);
    assign o_done         = (state_q == DONE);
    assign o_error        = err_q;
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 16x8 RAM
// and an optional stuck-at-zero read fault on address 1.
module tb_ram_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [4:0] len = '0;
    logic       hold;
    logic       busy;
    logic       done;
    logic       err;
    bit         fault = 1'b0;

    logic [7:0] mem [16];
    logic [7:0] stim [16];
    logic [7:0] wa [$];
    logic [7:0] wd [$];
    longint     wt [$];
    longint     t1;
    int         passed = 0;
    int         failed = 0;
    int         total = 0;
    int         dcyc;

    ram_loader_if #(.DATA_WIDTH(8)) bus ();

    ram_loader #(
        .DATA_WIDTH(8),
        .MEM_SIZE  (16),
        .ADDR_WIDTH(4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_len     (len),
        .bus       (bus.master),
        .o_cpu_hold(hold),
        .o_busy    (busy),
        .o_done    (done),
        .o_error   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.o_we) mem[bus.o_addr[3:0]] <= bus.o_bus_data;
    end

    assign bus.i_ram_data = (fault && bus.o_addr == 8'd1) ?
                            8'h00 : mem[bus.o_addr[3:0]];

    always @(negedge clk) begin
        if (bus.o_we) begin
            wa.push_back(bus.o_addr);
            wd.push_back(bus.o_bus_data);
            wt.push_back($time);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, bus.o_ready, 0);
        chk({p, "_we"}, bus.o_we, 0);
        chk({p, "_addr"}, bus.o_addr, 0);
        chk({p, "_wdata"}, bus.o_bus_data, 0);
        chk({p, "_jmp"}, bus.o_jmp_imme, 0);
        chk({p, "_hold"}, hold, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_err"}, err, 0);
    endtask

    // Called just after a falling edge; returns on the cycle o_done is seen.
    task automatic do_load(input logic [4:0] l, input int n,
                           input logic [7:0] ck, input bit alt,
                           input bit pstart, output int dc);
        int idx;
        int cyc;
        bit v;
        bit hs;
        wa.delete();
        wd.delete();
        wt.delete();
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        t1 = $time;
        chk("start_ready", bus.o_ready, 1);
        chk("start_busy", busy, 1);
        chk("start_hold", hold, 1);
        chk("start_err", err, 0);
        idx = 0;
        v = 1'b1;
        while (idx <= n && cyc < 400) begin
            bus.i_valid = v;
            bus.i_data = (idx < n) ? stim[idx] : ck;
            if (pstart && idx == 1) begin
                start = 1'b1;
                len = 5'd7;
            end else begin
                start = 1'b0;
            end
            hs = v && bus.o_ready;
            @(negedge clk);
            cyc++;
            if (hs) idx++;
            if (alt) v = ~v;
        end
        bus.i_valid = 1'b0;
        start = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", done, 1);
        dc = cyc;
    endtask

    task automatic chk_writes(input string p, input int n, input int step);
        chk({p, "_nwr"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            chk({p, "_wa"}, wa[i], i);
            chk({p, "_wd"}, wd[i], stim[i]);
            chk({p, "_wt"}, 32'((wt[i] - t1) / 10), 1 + step * (i + 1) - step + 1 - 1);
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        #2 rst_n = 1'b0;
        #1 chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        stim[0] = 8'h12;
        stim[1] = 8'h34;
        stim[2] = 8'h56;
        do_load(5'd3, 3, 8'h64, 1'b0, 1'b0, dcyc);
        chk("good_dcyc", dcyc, 8);
        chk("good_err", err, 0);
        chk("good_hold_at_done", hold, 1);
        chk_writes("good", 3, 1);
        @(negedge clk);
        chk("good_hold_after", hold, 0);
        chk("good_busy_after", busy, 0);
        chk("good_done_after", done, 0);
        for (int i = 0; i < 3; i++) chk("good_mem", mem[i], stim[i]);

        do_load(5'd3, 3, 8'h65, 1'b0, 1'b0, dcyc);
        chk("bad_dcyc", dcyc, 8);
        chk("bad_err", err, 1);
        chk("bad_nwr", wa.size(), 3);
        repeat (3) @(negedge clk);
        chk("bad_err_sticky", err, 1);

        for (int i = 0; i < 16; i++) stim[i] = 8'(i);
        do_load(5'd0, 16, 8'h88, 1'b0, 1'b0, dcyc);
        chk("full_dcyc", dcyc, 34);
        chk("full_err", err, 0);
        chk_writes("full", 16, 1);
        @(negedge clk);

        stim[0] = 8'h12;
        stim[1] = 8'h34;
        stim[2] = 8'h56;
        do_load(5'd3, 3, 8'h64, 1'b1, 1'b1, dcyc);
        chk("bp_dcyc", dcyc, 11);
        chk("bp_err", err, 0);
        chk_writes("bp", 3, 2);
        @(negedge clk);
        chk("bp_busy_after", busy, 0);
        for (int i = 0; i < 3; i++) chk("bp_mem", mem[i], stim[i]);

        start = 1'b1;
        len = 5'd3;
        @(negedge clk);
        start = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data = 8'hA1;
        @(negedge clk);
        bus.i_data = 8'hB2;
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("mid_we_inflight", bus.o_we, 1);
        chk("mid_addr_inflight", bus.o_addr, 1);
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        stim[0] = 8'hA1;
        stim[1] = 8'hB2;
        stim[2] = 8'hC3;
        do_load(5'd3, 3, 8'hEA, 1'b0, 1'b0, dcyc);
        chk("fresh_dcyc", dcyc, 8);
        chk("fresh_err", err, 0);
        chk_writes("fresh", 3, 1);
        @(negedge clk);

        fault = 1'b1;
        stim[0] = 8'h12;
        stim[1] = 8'h34;
        stim[2] = 8'h56;
        do_load(5'd3, 3, 8'h64, 1'b0, 1'b0, dcyc);
        chk("fault_err", err, 1);
        chk("fault_nwr", wa.size(), 3);
        fault = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
